// File: rtl/moore_fsm_nol_pkg.sv
// Shared types and constants for the non-overlapping 1101 Moore detector.
// State encoding is fixed binary so the unused codes 5..7 are well defined.
package moore_fsm_nol_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S1   = 3'd1,
      S11  = 3'd2,
      S110 = 3'd3,
      DET  = 3'd4
   } state_e;

   localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/moore_fsm_nol.sv
// Serial 1101 pattern detector, Moore FSM, non-overlapping matches.
// The match flag is decoded from the state register only.
module moore_fsm_nol
   import moore_fsm_nol_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   state_e state_q;
   state_e state_d;

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = in ? S1   : IDLE;
         S1:      state_d = in ? S11  : IDLE;
         S11:     state_d = in ? S11  : S110;
         S110:    state_d = in ? DET  : IDLE;
         // A 1 after a match starts a fresh prefix; no bit reuse.
         DET:     state_d = in ? S1   : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign out = (state_q == DET);

endmodule

// File: tb/tb_moore_fsm_nol.sv
// Directed and random bench for the 1101 non-overlapping Moore detector.
// Inputs change on the falling edge; out is sampled 1 time unit after rising.
module tb_moore_fsm_nol;
   import moore_fsm_nol_pkg::*;

   logic clk;
   logic rst;
   logic in_b;
   logic out_b;

   int checks;
   int failures;

   logic [3:0] mdl_h;
   int         mdl_cnt;

   moore_fsm_nol dut (
      .clk (clk),
      .rst (rst),
      .in  (in_b),
      .out (out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic b, output logic o);
      @(negedge clk);
      in_b = b;
      @(posedge clk);
      #1;
      o = out_b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_b = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic o;
      logic [3:0] bits;
      logic [4:0] ebits;
      rst = 1'b1;
      in_b = 1'b1;
      #1;
      checks++;
      if (out_b !== 1'b0) begin
         failures++;
         $display("FAIL reset_async out=%b exp=0", out_b);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_b !== 1'b0) begin
         failures++;
         $display("FAIL reset_hold_edge out=%b exp=0", out_b);
      end
      @(negedge clk);
      rst = 1'b0;
      bits  = 4'b1101;
      ebits = 5'b00010;
      for (int i = 0; i < 5; i++) begin
         step((i < 4) ? bits[3-i] : 1'b0, o);
         checks++;
         if (o !== ebits[4-i]) begin
            failures++;
            $display("FAIL reset_first_match bit%0d out=%b exp=%b",
                     i, o, ebits[4-i]);
         end
      end
   endtask

   task automatic test_non_overlap();
      logic o;
      logic [7:0] bits;
      logic [7:0] ebits;
      do_reset();
      bits  = 8'b1101_1011;
      ebits = 8'b0001_0000;
      for (int i = 0; i < 8; i++) begin
         step(bits[7-i], o);
         checks++;
         if (o !== ebits[7-i]) begin
            failures++;
            $display("FAIL non_overlap bit%0d out=%b exp=%b",
                     i, o, ebits[7-i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic o;
      logic [11:0] bits;
      logic [11:0] ebits;
      logic [7:0] b2;
      logic [7:0] e2;
      do_reset();
      bits  = 12'b1101_1101_1101;
      ebits = 12'b0001_0001_0001;
      for (int i = 0; i < 12; i++) begin
         step(bits[11-i], o);
         checks++;
         if (o !== ebits[11-i]) begin
            failures++;
            $display("FAIL repeat3 bit%0d out=%b exp=%b",
                     i, o, ebits[11-i]);
         end
      end
      do_reset();
      b2 = 8'b1101_1101;
      e2 = 8'b0001_0001;
      for (int i = 0; i < 8; i++) begin
         step(b2[7-i], o);
         checks++;
         if (o !== e2[7-i]) begin
            failures++;
            $display("FAIL b2b bit%0d out=%b exp=%b", i, o, e2[7-i]);
         end
      end
   endtask

   task automatic test_self_loop();
      logic o;
      logic [4:0] bits;
      logic [4:0] ebits;
      logic [7:0] b2;
      logic [7:0] e2;
      do_reset();
      bits  = 5'b11101;
      ebits = 5'b00001;
      for (int i = 0; i < 5; i++) begin
         step(bits[4-i], o);
         checks++;
         if (o !== ebits[4-i]) begin
            failures++;
            $display("FAIL self_loop bit%0d out=%b exp=%b",
                     i, o, ebits[4-i]);
         end
      end
      do_reset();
      b2 = 8'b1100_1101;
      e2 = 8'b0000_0001;
      for (int i = 0; i < 8; i++) begin
         step(b2[7-i], o);
         checks++;
         if (o !== e2[7-i]) begin
            failures++;
            $display("FAIL s110_fail bit%0d out=%b exp=%b", i, o, e2[7-i]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic o;
      logic [3:0] bits;
      logic [3:0] ebits;
      do_reset();
      step(1'b1, o);
      step(1'b1, o);
      step(1'b0, o);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_b !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst out=%b exp=0", out_b);
      end
      #1 rst = 1'b0;
      bits  = 4'b1101;
      ebits = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         step(bits[3-i], o);
         checks++;
         if (o !== ebits[3-i]) begin
            failures++;
            $display("FAIL mid_rst_restart bit%0d out=%b exp=%b",
                     i, o, ebits[3-i]);
         end
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (out_b !== 1'b0) begin
         failures++;
         $display("FAIL det_rst_async out=%b exp=0", out_b);
      end
      #1 rst = 1'b0;
      step(1'b0, o);
      checks++;
      if (o !== 1'b0) begin
         failures++;
         $display("FAIL det_rst_after out=%b exp=0", o);
      end
   endtask

   task automatic test_random();
      logic o;
      logic b;
      logic e;
      do_reset();
      mdl_h = 4'b0000;
      mdl_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         b = 1'($urandom_range(0, 1));
         step(b, o);
         mdl_h = {mdl_h[2:0], b};
         mdl_cnt++;
         e = (mdl_cnt >= 4) && (mdl_h == PATTERN);
         if (e) mdl_cnt = 0;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL random bit%0d in=%b out=%b exp=%b", i, b, o, e);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      in_b = 1'b0;
      test_reset();
      test_non_overlap();
      test_back_to_back();
      test_self_loop();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
